// File: rtl/forward_scoreboard.sv
// Forwarding and hazard unit for the in-order MIPS32 pipeline.
// Keeps the destinations of the last DEPTH fired instructions in a shift
// register of slots. For the instruction in ID it picks the youngest
// producer tap for rs and rt, and stalls while that producer's result is
// still in flight. Also counts stall cycles, saturating at all-ones.
module forward_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  iss_valid,
    input  logic                  iss_rs_read,
    input  logic                  iss_rt_read,
    input  logic [REG_ADDR_W-1:0] iss_rs_addr,
    input  logic [REG_ADDR_W-1:0] iss_rt_addr,
    input  logic                  iss_reg_write,
    input  logic [REG_ADDR_W-1:0] iss_wr_addr,
    input  logic [SEL_W-1:0]      iss_lat,
    output logic                  stall,
    output logic                  iss_fire,
    output logic [SEL_W-1:0]      rs_fwd_sel,
    output logic [SEL_W-1:0]      rt_fwd_sel,
    output logic [31:0]           perf_stall_cnt
);

    localparam logic [SEL_W-1:0] DEPTH_SEL = SEL_W'(DEPTH);
    localparam logic [SEL_W-1:0] ONE_SEL   = SEL_W'(1);

    // Slot k of the pipeline lives at array index k-1.
    logic [DEPTH-1:0]      v_q, v_d;
    logic [REG_ADDR_W-1:0] addr_q [DEPTH];
    logic [REG_ADDR_W-1:0] addr_d [DEPTH];
    logic [SEL_W-1:0]      lat_q  [DEPTH];
    logic [SEL_W-1:0]      lat_d  [DEPTH];
    logic [31:0]           cnt_q, cnt_d;

    logic                  rs_req, rt_req;
    logic                  rs_hit, rt_hit;
    logic [SEL_W-1:0]      rs_k, rt_k;
    logic [SEL_W-1:0]      rs_lat, rt_lat;
    logic                  rs_stall, rt_stall;
    logic [SEL_W-1:0]      lat_clamped;

    // Youngest-producer search for both sources, plus stall and select decode.
    always_comb begin
        rs_hit = 1'b0;
        rs_k   = '0;
        rs_lat = '0;
        rt_hit = 1'b0;
        rt_k   = '0;
        rt_lat = '0;
        // Walk oldest to youngest so the youngest match overwrites older ones.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (v_q[k] && (addr_q[k] == iss_rs_addr)) begin
                rs_hit = 1'b1;
                rs_k   = SEL_W'(k + 1);
                rs_lat = lat_q[k];
            end
            if (v_q[k] && (addr_q[k] == iss_rt_addr)) begin
                rt_hit = 1'b1;
                rt_k   = SEL_W'(k + 1);
                rt_lat = lat_q[k];
            end
        end
        rs_req     = iss_valid & iss_rs_read & (iss_rs_addr != '0);
        rt_req     = iss_valid & iss_rt_read & (iss_rt_addr != '0);
        rs_stall   = rs_req & rs_hit & (rs_lat > rs_k);
        rt_stall   = rt_req & rt_hit & (rt_lat > rt_k);
        rs_fwd_sel = (rs_req & rs_hit & ~rs_stall) ? rs_k : '0;
        rt_fwd_sel = (rt_req & rt_hit & ~rt_stall) ? rt_k : '0;
        stall      = iss_valid & (rs_stall | rt_stall) & ~freeze;
        iss_fire   = iss_valid & ~stall & ~freeze;
    end

    // Next slot contents: shift one place per non-frozen cycle, capture at slot 1.
    always_comb begin
        if (iss_lat == '0) begin
            lat_clamped = ONE_SEL;
        end else if (iss_lat > DEPTH_SEL) begin
            lat_clamped = DEPTH_SEL;
        end else begin
            lat_clamped = iss_lat;
        end
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) begin
            addr_d[k] = addr_q[k];
            lat_d[k]  = lat_q[k];
        end
        if (!freeze) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                v_d[k]    = v_q[k-1];
                addr_d[k] = addr_q[k-1];
                lat_d[k]  = lat_q[k-1];
            end
            v_d[0]    = iss_fire & iss_reg_write & (iss_wr_addr != '0);
            addr_d[0] = iss_wr_addr;
            lat_d[0]  = lat_clamped;
        end
    end

    // Saturating stall-cycle counter; stall is already low while frozen.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // State registers; reset drops every slot so nothing pre-reset is forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                lat_q[k]  <= '0;
            end
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= addr_d[k];
                lat_q[k]  <= lat_d[k];
            end
        end
    end

    assign perf_stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard (DEPTH = 3). Expected outputs are
// queued as each step is driven and popped when the outputs are sampled.
module tb_forward_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        iss_valid;
    logic        iss_rs_read;
    logic        iss_rt_read;
    logic [4:0]  iss_rs_addr;
    logic [4:0]  iss_rt_addr;
    logic        iss_reg_write;
    logic [4:0]  iss_wr_addr;
    logic [2:0]  iss_lat;
    logic        stall;
    logic        iss_fire;
    logic [2:0]  rs_fwd_sel;
    logic [2:0]  rt_fwd_sel;
    logic [31:0] perf_stall_cnt;

    typedef struct {
        string    tag;
        logic     stall;
        logic     fire;
        logic [2:0] rs;
        logic [2:0] rt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_cnt;
    logic        last_exp_stall;

    forward_scoreboard #(
        .REG_ADDR_W(5),
        .DEPTH(3),
        .SEL_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .freeze(freeze),
        .iss_valid(iss_valid),
        .iss_rs_read(iss_rs_read),
        .iss_rt_read(iss_rt_read),
        .iss_rs_addr(iss_rs_addr),
        .iss_rt_addr(iss_rt_addr),
        .iss_reg_write(iss_reg_write),
        .iss_wr_addr(iss_wr_addr),
        .iss_lat(iss_lat),
        .stall(stall),
        .iss_fire(iss_fire),
        .rs_fwd_sel(rs_fwd_sel),
        .rt_fwd_sel(rt_fwd_sel),
        .perf_stall_cnt(perf_stall_cnt)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_stimulus(input logic valid, input logic frz,
                                  input logic rs_rd, input logic [4:0] rs,
                                  input logic rt_rd, input logic [4:0] rt,
                                  input logic wr, input logic [4:0] wa,
                                  input logic [2:0] lat);
        iss_valid     = valid;
        freeze        = frz;
        iss_rs_read   = rs_rd;
        iss_rs_addr   = rs;
        iss_rt_read   = rt_rd;
        iss_rt_addr   = rt;
        iss_reg_write = wr;
        iss_wr_addr   = wa;
        iss_lat       = lat;
    endtask

    task automatic expect_out(input string tag, input logic s, input logic f,
                              input logic [2:0] rs, input logic [2:0] rt);
        exp_t e;
        e.tag   = tag;
        e.stall = s;
        e.fire  = f;
        e.rs    = rs;
        e.rt    = rt;
        exp_q.push_back(e);
        last_exp_stall = s;
    endtask

    task automatic check_output();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            assert (stall === e.stall) else begin
                n_fail++;
                $error("[TB] FAIL %s.stall got %b want %b", e.tag, stall, e.stall);
            end
            n_checks++;
            assert (iss_fire === e.fire) else begin
                n_fail++;
                $error("[TB] FAIL %s.fire got %b want %b", e.tag, iss_fire, e.fire);
            end
            n_checks++;
            assert (rs_fwd_sel === e.rs) else begin
                n_fail++;
                $error("[TB] FAIL %s.rs_sel got %0d want %0d", e.tag, rs_fwd_sel, e.rs);
            end
            n_checks++;
            assert (rt_fwd_sel === e.rt) else begin
                n_fail++;
                $error("[TB] FAIL %s.rt_sel got %0d want %0d", e.tag, rt_fwd_sel, e.rt);
            end
            n_checks++;
            assert (perf_stall_cnt === exp_cnt) else begin
                n_fail++;
                $error("[TB] FAIL %s.cnt got %0d want %0d", e.tag, perf_stall_cnt, exp_cnt);
            end
        end
    endtask

    // Advance one clock; the counter model follows the expected stall.
    task automatic tick();
        @(posedge clk);
        if (rst_n && last_exp_stall) exp_cnt = exp_cnt + 32'd1;
        last_exp_stall = 1'b0;
        #1;
    endtask

    task automatic step(input string tag, input logic valid, input logic frz,
                        input logic rs_rd, input logic [4:0] rs,
                        input logic rt_rd, input logic [4:0] rt,
                        input logic wr, input logic [4:0] wa, input logic [2:0] lat,
                        input logic s, input logic f,
                        input logic [2:0] ers, input logic [2:0] ert);
        apply_stimulus(valid, frz, rs_rd, rs, rt_rd, rt, wr, wa, lat);
        expect_out(tag, s, f, ers, ert);
        #1;
        check_output();
        tick();
    endtask

    // Directed sequence covering the main forwarding and hazard scenarios.
    initial begin
        n_checks       = 0;
        n_fail         = 0;
        exp_cnt        = 32'd0;
        last_exp_stall = 1'b0;
        rst_n          = 1'b0;
        apply_stimulus(1, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0, 3'd1);
        expect_out("reset", 0, 1, 0, 0);
        #2;
        check_output();
        tick();
        rst_n = 1'b1;
        tick();

        // ALU back-to-back
        step("alu_prod", 1, 0, 0, 0, 0, 0, 1, 5'd5, 3'd1, 0, 1, 0, 0);
        step("alu_use",  1, 0, 1, 5'd5, 0, 0, 0, 0, 3'd1, 0, 1, 1, 0);

        // Load-use: one stall, then forward from tap 2
        step("ld_prod",  1, 0, 0, 0, 0, 0, 1, 5'd8, 3'd2, 0, 1, 0, 0);
        step("ld_stall", 1, 0, 0, 0, 1, 5'd8, 1, 5'd9, 3'd1, 1, 0, 0, 0);
        step("ld_use",   1, 0, 0, 0, 1, 5'd8, 1, 5'd9, 3'd1, 0, 1, 0, 2);

        // Latest policy; r8 has aged out by now
        step("r3_a",     1, 0, 0, 0, 0, 0, 1, 5'd3, 3'd1, 0, 1, 0, 0);
        step("r3_b",     1, 0, 0, 0, 0, 0, 1, 5'd3, 3'd1, 0, 1, 0, 0);
        step("latest",   1, 0, 1, 5'd3, 1, 5'd8, 0, 0, 3'd1, 0, 1, 1, 0);

        // Zero register is never a hazard
        step("r0_prod",  1, 0, 0, 0, 0, 0, 1, 5'd0, 3'd2, 0, 1, 0, 0);
        step("r0_use",   1, 0, 1, 5'd0, 1, 5'd0, 0, 0, 3'd1, 0, 1, 0, 0);

        // Aging out without freeze
        step("r7_prod",  1, 0, 0, 0, 0, 0, 1, 5'd7, 3'd1, 0, 1, 0, 0);
        step("age_b1",   0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0);
        step("age_b2",   0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0);
        step("age_t3",   1, 0, 1, 5'd7, 0, 0, 0, 0, 3'd1, 0, 1, 3, 0);
        step("age_t4",   1, 0, 1, 5'd7, 0, 0, 0, 0, 3'd1, 0, 1, 0, 0);

        // Aging out with two frozen cycles in between
        step("fr_prod",  1, 0, 0, 0, 0, 0, 1, 5'd7, 3'd1, 0, 1, 0, 0);
        step("fr_t1",    1, 1, 1, 5'd7, 0, 0, 1, 5'd6, 3'd1, 0, 0, 1, 0);
        step("fr_t2",    1, 1, 1, 5'd7, 0, 0, 1, 5'd6, 3'd1, 0, 0, 1, 0);
        step("fr_t3",    0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0);
        step("fr_t4",    0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0);
        step("fr_t5",    1, 0, 1, 5'd7, 0, 0, 0, 0, 3'd1, 0, 1, 3, 0);
        step("fr_t6",    1, 0, 1, 5'd7, 0, 0, 0, 0, 3'd1, 0, 1, 0, 0);

        // Simultaneous rs/rt dependence; lat 7 clamps to 3
        step("dual_p10", 1, 0, 0, 0, 0, 0, 1, 5'd10, 3'd7, 0, 1, 0, 0);
        step("dual_p11", 1, 0, 0, 0, 0, 0, 1, 5'd11, 3'd1, 0, 1, 0, 0);
        step("dual_stl", 1, 0, 1, 5'd10, 1, 5'd11, 0, 0, 3'd1, 1, 0, 0, 1);
        step("dual_go",  1, 0, 1, 5'd10, 1, 5'd11, 0, 0, 3'd1, 0, 1, 3, 2);

        // Reset arriving during a load-use stall
        step("rst_prod", 1, 0, 0, 0, 0, 0, 1, 5'd8, 3'd2, 0, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 1, 5'd8, 0, 0, 3'd1);
        expect_out("rst_stl", 1, 0, 0, 0);
        #1;
        check_output();
        rst_n = 1'b0;
        exp_cnt = 32'd0;
        expect_out("rst_low", 0, 1, 0, 0);
        #1;
        check_output();
        tick();
        rst_n = 1'b1;
        step("rst_after", 1, 0, 0, 0, 1, 5'd8, 0, 0, 3'd1, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised forwarding and hazard unit for the in-order MIPS32 pipeline. It tracks the destination registers of the last `DEPTH` issued instructions in a shift register of pipeline slots. For the instruction issuing out of ID, it selects which forwarding tap supplies each source operand, with the youngest producer winning. It raises a stall when the producer's result is not yet available at its tap, which covers load-use and any multi-cycle result latency up to `DEPTH`. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `REG_ADDR_W`, 5: register address width; address 0 is the hard-wired zero register.
- `DEPTH`, 3: number of forwarding taps. Tap 1 is EX/MEM, tap 2 is MEM/WB, tap `DEPTH` is the write-back bypass. Legal range is 1..7.
- `SEL_W`, 3: width of the select and latency fields; must satisfy 2^`SEL_W` > `DEPTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `freeze`  in  1  global pipeline freeze (e.g. cache miss); holds all state.
- `iss_valid`  in  1  an instruction is present in ID.
- `iss_rs_read`, `iss_rt_read`  in  1 each  the instruction reads rs / rt.
- `iss_rs_addr`, `iss_rt_addr`  in  `REG_ADDR_W` each  source register addresses.
- `iss_reg_write`  in  1  the instruction writes a register.
- `iss_wr_addr`  in  `REG_ADDR_W`  destination register address.
- `iss_lat`  in  `SEL_W`  first tap at which the result is valid: 1 for ALU/PC+4/IMM results, 2 for loads.
- `stall`  out  1  hold ID and inject a bubble into EX; combinational.
- `iss_fire`  out  1  `iss_valid & ~stall & ~freeze`; combinational.
- `rs_fwd_sel`, `rt_fwd_sel`  out  `SEL_W` each  operand source: 0 = register file, k = tap k; combinational.
- `perf_stall_cnt`  out  32  count of stall cycles; registered.

## Operation
- **State.** Slots 1..`DEPTH`, each holding {`v`, `addr`, `lat`}.
  - Slot k holds the instruction that fired k cycles ago, counting only non-frozen cycles.
- **Latency clamp.** On capture, `lat` is clamped: 0 is stored as 1, and values above `DEPTH` are stored as `DEPTH`.
- **Match rule.** A source is evaluated only when its read flag is 1, its address is not 0, and `iss_valid` is 1.
  - Search slots 1..`DEPTH`, lowest k first. The first slot with `v` = 1 and `addr` equal to the source address is the producer; older matches are ignored (latest policy).
  - No producer: select = 0 and the source contributes no stall.
  - Producer at slot k with `lat` ≤ k: select = k and no stall.
  - Producer at slot k with `lat` > k: the source requests a stall, and its select value is 0 but must be ignored.
- **Stall.**
  - `stall` is the OR of the rs and rt stall requests, gated by `iss_valid`.
  - `stall` is forced to 0 while `freeze` = 1.
- **Shift, when `freeze` = 0.**
  - Slot k+1 takes slot k. Slot `DEPTH` contents are discarded, because the register file holds that value from then on.
  - Slot 1 takes {1, `iss_wr_addr`, clamped `iss_lat`} if `iss_fire` & `iss_reg_write` & `iss_wr_addr` ≠ 0; otherwise it takes a bubble (`v` = 0).
- **Freeze.** When `freeze` = 1, all slots and the counter hold. Select outputs remain combinationally valid.
- **Counter.** `perf_stall_cnt` increments on each edge where `stall` = 1, and saturates at 0xFFFFFFFF.
- **Source as destination.** A source equal to the instruction's own destination is not a hazard. The search covers older slots only.

## Timing
- **Reset.** Asserting `rst_n` low immediately clears every slot's `v` and sets `perf_stall_cnt` = 0.
  - While in reset: `stall` = 0, `rs_fwd_sel` = `rt_fwd_sel` = 0, and `iss_fire` = `iss_valid & ~freeze`.
  - Reset may arrive mid-stall. After release, no forwarding from pre-reset instructions occurs.
- **Latency.**
  - Select and stall outputs have zero-cycle latency from the `iss_*` inputs and the current slot state.
  - A fired producer first becomes visible to the next cycle's issue at slot 1.
- **Stall duration.** A producer with `lat` = L fired at cycle t stalls a dependant at cycle t+k for every k < L. The dependant fires at cycle t+L with select = L, provided there is no freeze.
- **Simultaneous rs/rt dependence.** Each source uses its own producer; the stall lasts until both are satisfied.
- **Aging out.** A producer older than `DEPTH` cycles is no longer visible, and select returns to 0.

## Test plan
- **ALU back-to-back.** Fire r5 (lat 1) at t; at t+1 rs = r5 → `stall` = 0, `rs_fwd_sel` = 1.
- **Load-use.** Fire r8 (lat 2) at t; at t+1 rt = r8 → `stall` = 1 and `perf_stall_cnt` becomes 1. At t+2 → `stall` = 0, `rt_fwd_sel` = 2.
- **Latest policy.** Fire r3 (lat 1) at t and again at t+1; at t+2 rs = r3 → `rs_fwd_sel` = 1, not 2.
- **Zero register.** Fire r0 (lat 2); next cycle rs = rt = r0 → `stall` = 0, both selects 0.
- **Aging out and freeze.**
  - `DEPTH` = 3: fire r7 at t; at t+3 → select 3; at t+4 → select 0.
  - Repeat with `freeze` = 1 for 2 cycles in between → select 3 appears at t+5.
- **Reset mid-stall.** Fire r8 (lat 2), then pull `rst_n` low during the stall cycle → `stall` drops immediately. After release, rt = r8 → select 0 and `perf_stall_cnt` = 0.
